// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I memory stage: EX/MEM register, data memory handshake, load extend, MEM/WB register
module memory_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid_e,
  input  logic [WIDTH-1:0] i_alu_result_e,
  input  logic [WIDTH-1:0] i_write_data_e,
  input  logic [WIDTH-1:0] i_pc_plus4_e,
  input  logic [4:0]       i_rd_e,
  input  logic             i_reg_write_e,
  input  logic             i_mem_read_e,
  input  logic             i_mem_write_e,
  input  logic [1:0]       i_result_src_e,
  input  logic [2:0]       i_funct3_e,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic [3:0]       o_mem_be,
  input  logic             i_mem_ready,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_stall_m,
  output logic [WIDTH-1:0] o_alu_result_m,
  output logic [4:0]       o_rd_m,
  output logic             o_reg_write_m,
  output logic             o_valid_w,
  output logic             o_reg_write_w,
  output logic [1:0]       o_result_src_w,
  output logic [4:0]       o_rd_w,
  output logic [WIDTH-1:0] o_alu_result_w,
  output logic [WIDTH-1:0] o_read_data_w,
  output logic [WIDTH-1:0] o_pc_plus4_w,
  output logic             o_misalign_m,
  output logic             o_bus_err_m
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;

  logic             r_valid_m;
  logic [WIDTH-1:0] r_alu_m;
  logic [WIDTH-1:0] r_wdata_m;
  logic [WIDTH-1:0] r_pc4_m;
  logic [4:0]       r_rd_m;
  logic             r_reg_write_m;
  logic             r_mem_read_m;
  logic             r_mem_write_m;
  logic [1:0]       r_result_src_m;
  logic [2:0]       r_funct3_m;

  logic             w_acc;
  logic             w_aligned;
  logic             w_abort;
  logic             w_req;
  logic             w_stall;
  logic             w_misalign;
  logic             w_load_done;
  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_load_data;

  assign w_off = r_alu_m[1:0];
  assign w_acc = r_valid_m & (r_mem_read_m | r_mem_write_m);

  always_comb begin
    w_aligned = 1'b0;
    case (r_funct3_m[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~w_off[0];
      2'b10:   w_aligned = (w_off == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // Abort fires on the last permitted wait cycle so the request is dropped in the same cycle.
  assign w_abort     = (r_state == S_WAIT) && (r_count == C_LAST) && !i_mem_ready;
  assign w_req       = w_acc & w_aligned & ~w_abort;
  assign w_stall     = w_req & ~i_mem_ready;
  assign w_misalign  = w_acc & ~w_aligned;
  assign w_load_done = w_req & ~r_mem_write_m & i_mem_ready;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata_m;
    case (r_funct3_m[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = WIDTH'({4{r_wdata_m[7:0]}});
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = WIDTH'({2{r_wdata_m[15:0]}});
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata_m;
      end
    endcase
  end

  always_comb begin
    w_byte = i_mem_rdata[7:0];
    case (w_off)
      2'd0: w_byte = i_mem_rdata[7:0];
      2'd1: w_byte = i_mem_rdata[15:8];
      2'd2: w_byte = i_mem_rdata[23:16];
      2'd3: w_byte = i_mem_rdata[31:24];
      default: w_byte = i_mem_rdata[7:0];
    endcase
    w_half = w_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_funct3_m)
      3'b000:  w_load_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(WIDTH-16){1'b0}}, w_half};
      default: w_load_data = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_m      <= 1'b0;
      r_alu_m        <= '0;
      r_wdata_m      <= '0;
      r_pc4_m        <= '0;
      r_rd_m         <= '0;
      r_reg_write_m  <= 1'b0;
      r_mem_read_m   <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= '0;
      r_funct3_m     <= '0;
    end else if (!w_stall) begin
      r_valid_m      <= i_valid_e;
      r_alu_m        <= i_alu_result_e;
      r_wdata_m      <= i_write_data_e;
      r_pc4_m        <= i_pc_plus4_e;
      r_rd_m         <= i_rd_e;
      r_reg_write_m  <= i_reg_write_e;
      r_mem_read_m   <= i_mem_read_e;
      r_mem_write_m  <= i_mem_write_e;
      r_result_src_m <= i_result_src_e;
      r_funct3_m     <= i_funct3_e;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !i_mem_ready) begin
            r_state <= S_WAIT;
            r_count <= CW'(1);
          end
        end
        S_WAIT: begin
          if (i_mem_ready || w_abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // While stalled, W receives a bubble but keeps its data fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_w      <= 1'b0;
      o_reg_write_w  <= 1'b0;
      o_result_src_w <= '0;
      o_rd_w         <= '0;
      o_alu_result_w <= '0;
      o_read_data_w  <= '0;
      o_pc_plus4_w   <= '0;
    end else if (w_stall) begin
      o_valid_w     <= 1'b0;
      o_reg_write_w <= 1'b0;
    end else begin
      o_valid_w      <= r_valid_m;
      o_reg_write_w  <= r_valid_m & r_reg_write_m & ~r_mem_write_m & ~w_misalign & ~w_abort;
      o_result_src_w <= r_result_src_m;
      o_rd_w         <= r_rd_m;
      o_alu_result_w <= r_alu_m;
      o_pc_plus4_w   <= r_pc4_m;
      if (w_load_done) o_read_data_w <= w_load_data;
    end
  end

  assign o_mem_req      = w_req;
  assign o_mem_we       = r_mem_write_m;
  assign o_mem_addr     = {r_alu_m[WIDTH-1:2], 2'b00};
  assign o_mem_wdata    = w_wdata;
  assign o_mem_be       = w_be;
  assign o_stall_m      = w_stall;
  assign o_alu_result_m = r_alu_m;
  assign o_rd_m         = r_rd_m;
  assign o_reg_write_m  = r_valid_m & r_reg_write_m;
  assign o_misalign_m   = w_misalign;
  assign o_bus_err_m    = w_abort;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized bench for memory_stage against a transaction-level reference model
module tb_memory_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e, reg_write_e, mem_read_e, mem_write_e;
  logic [31:0] alu_e, wdata_e, pc4_e;
  logic [4:0]  rd_e;
  logic [1:0]  rsrc_e;
  logic [2:0]  f3_e;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall_m, reg_write_m, valid_w, reg_write_w, misalign_m, bus_err_m;
  logic [31:0] alu_m, alu_w, read_data_w, pc4_w;
  logic [4:0]  rd_m, rd_w;
  logic [1:0]  rsrc_w;

  int n_checks = 0;
  int n_errors = 0;

  memory_stage #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid_e(valid_e), .i_alu_result_e(alu_e),
    .i_write_data_e(wdata_e), .i_pc_plus4_e(pc4_e), .i_rd_e(rd_e),
    .i_reg_write_e(reg_write_e), .i_mem_read_e(mem_read_e), .i_mem_write_e(mem_write_e),
    .i_result_src_e(rsrc_e), .i_funct3_e(f3_e), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .o_stall_m(stall_m),
    .o_alu_result_m(alu_m), .o_rd_m(rd_m), .o_reg_write_m(reg_write_m),
    .o_valid_w(valid_w), .o_reg_write_w(reg_write_w), .o_result_src_w(rsrc_w),
    .o_rd_w(rd_w), .o_alu_result_w(alu_w), .o_read_data_w(read_data_w),
    .o_pc_plus4_w(pc4_w), .o_misalign_m(misalign_m), .o_bus_err_m(bus_err_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] rd, input int off);
    int n = size_of(f3);
    logic [31:0] v = rd >> (8 * off);
    if (n == 1) v = v & 32'hFF;
    if (n == 2) v = v & 32'hFFFF;
    if (!f3[2] && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = size_of(f3);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  task automatic drive_bubble();
    valid_e = 0; reg_write_e = 0; mem_read_e = 0; mem_write_e = 0;
    alu_e = 0; wdata_e = 0; pc4_e = 0; rd_e = 0; rsrc_e = 0; f3_e = 0;
  endtask

  // kind: 0 ALU op, 1 load, 2 store; lat: cycles before mem_ready rises
  task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata, input int lat,
                        input logic [4:0] rd);
    int n, off, nst;
    bit acc, al, go, abrt;
    logic [31:0] pc4;
    pc4 = $urandom;
    @(negedge clk);
    valid_e = 1; alu_e = addr; wdata_e = data; pc4_e = pc4; rd_e = rd; f3_e = f3;
    reg_write_e = (kind != 2); mem_read_e = (kind == 1); mem_write_e = (kind == 2);
    rsrc_e = (kind == 1) ? 2'b01 : 2'b00;
    mem_ready = 0;
    @(negedge clk);
    drive_bubble();
    n = size_of(f3); off = addr % 4;
    acc = (kind != 0); al = (off % n) == 0; go = acc && al;
    abrt = go && (lat >= TO);
    nst = go ? ((lat < TO - 1) ? lat : TO - 1) : 0;
    for (int k = 0; k <= nst; k++) begin
      if (k > 0) @(negedge clk);
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? rdata : $urandom;
      #1;
      check("mem_req", {31'b0, mem_req}, {31'b0, go && !(abrt && k == TO - 1)});
      check("stall_m", {31'b0, stall_m}, {31'b0, k < nst});
      check("bus_err_m", {31'b0, bus_err_m}, {31'b0, abrt && k == TO - 1});
      if (k == 0) begin
        check("misalign_m", {31'b0, misalign_m}, {31'b0, acc && !al});
        check("reg_write_m", {31'b0, reg_write_m}, {31'b0, kind != 2});
        if (go) begin
          check("mem_addr", mem_addr, addr & 32'hFFFFFFFC);
          check("mem_we", {31'b0, mem_we}, {31'b0, kind == 2});
          check("mem_be", {28'b0, mem_be}, (((32'd1 << n) - 1) << off) & 32'hF);
          if (kind == 2) check("mem_wdata", mem_wdata, model_wdata(f3, data));
        end
      end else begin
        check("w_bubble", {31'b0, valid_w}, 32'd0);
      end
    end
    @(negedge clk);
    mem_ready = 0;
    check("valid_w", {31'b0, valid_w}, 32'd1);
    check("reg_write_w", {31'b0, reg_write_w},
          {31'b0, (kind == 0) || (kind == 1 && go && !abrt)});
    check("rd_w", {27'b0, rd_w}, {27'b0, rd});
    check("alu_w", alu_w, addr);
    check("pc4_w", pc4_w, pc4);
    check("rsrc_w", {30'b0, rsrc_w}, (kind == 1) ? 32'd1 : 32'd0);
    if (kind == 1 && go && !abrt) check("read_data_w", read_data_w, model_load(f3, rdata, off));
  endtask

  initial begin
    logic [2:0] f3;
    int kind;
    rst = 1; mem_ready = 0; mem_rdata = 0;
    drive_bubble();
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_stall", {31'b0, stall_m}, 32'd0);
    check("rst_valid_w", {31'b0, valid_w}, 32'd0);
    check("rst_reg_write_w", {31'b0, reg_write_w}, 32'd0);
    check("rst_misalign", {31'b0, misalign_m}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err_m}, 32'd0);
    check("rst_read_data_w", read_data_w, 32'd0);
    rst = 0;

    run_op(1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 5'd3);
    run_op(1, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 5'd4);
    run_op(1, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0, 5'd5);
    run_op(2, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1, 5'd6);
    run_op(1, 3'b010, 32'h101, 32'h0, 32'h0, 0, 5'd7);
    run_op(1, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 3, 5'd8);
    run_op(1, 3'b010, 32'h204, 32'h0, 32'h11111111, 1000, 5'd9);
    run_op(0, 3'b000, 32'h55AA33CC, 32'h0, 32'h0, 0, 5'd10);

    // Reset while waiting on memory drops the pending access.
    @(negedge clk);
    valid_e = 1; alu_e = 32'h300; f3_e = 3'b010; mem_read_e = 1; reg_write_e = 1; rd_e = 5'd1;
    @(negedge clk);
    drive_bubble();
    #1 check("pre_rst_stall", {31'b0, stall_m}, 32'd1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("mid_rst_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_stall", {31'b0, stall_m}, 32'd0);
    check("mid_rst_valid_w", {31'b0, valid_w}, 32'd0);
    rst = 0;

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
      endcase
      if (kind == 2) f3[2] = 1'b0;
      run_op(kind, f3, $urandom, $urandom, $urandom, $urandom_range(0, 5), 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
